// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard detector and stall sequencer for the 5-stage RV32 pipeline.
// Inserts load-use / ID-branch bubbles, freezes on D-cache miss, flushes IF/ID on taken branches.
module hazard_stall_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IFID_valid_i,
  input  logic [4:0]       IFID_rs1_addr_i,
  input  logic [4:0]       IFID_rs2_addr_i,
  input  logic             IFID_rs2_used_i,
  input  logic             IFID_branch_i,
  input  logic             branch_taken_i,
  input  logic [4:0]       IDEX_rd_addr_i,
  input  logic             IDEX_RegWrite_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       EXMEM_rd_addr_i,
  input  logic             EXMEM_MemRead_i,
  input  logic             mem_stall_i,
  output logic             PCWrite_o,
  output logic             IFID_Write_o,
  output logic             IDEX_NoOp_o,
  output logic             IFID_Flush_o,
  output logic             pipe_freeze_o,
  output logic [CNT_W-1:0] hazard_cnt_o,
  output logic [CNT_W-1:0] freeze_cnt_o
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] STALL   = 2'd1;
  localparam logic [1:0] MEMWAIT = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != CNT_MAX)) ? v + CNT_ONE : v;
  endfunction

  logic [1:0]       state, stateNext;
  logic [1:0]       retState, retStateNext;
  logic [1:0]       curState;
  logic             rem, remNext;
  logic [CNT_W-1:0] hazardCnt, freezeCnt;
  logic             hazInc, frzInc;

  logic exMatch, memMatch;
  logic hLu, hBex, hBmem;
  logic hazard, twoBubble;

  // Operand match against the producer in EX and in MEM; x0 never creates a dependency.
  assign exMatch  = (IDEX_rd_addr_i != 5'd0) &&
                    ((IDEX_rd_addr_i == IFID_rs1_addr_i) ||
                     (IFID_rs2_used_i && (IDEX_rd_addr_i == IFID_rs2_addr_i)));
  assign memMatch = (EXMEM_rd_addr_i != 5'd0) &&
                    ((EXMEM_rd_addr_i == IFID_rs1_addr_i) ||
                     (IFID_rs2_used_i && (EXMEM_rd_addr_i == IFID_rs2_addr_i)));

  assign hLu       = IDEX_MemRead_i & exMatch;
  assign hBex      = IFID_branch_i & IDEX_RegWrite_i & ~IDEX_MemRead_i & exMatch;
  assign hBmem     = IFID_branch_i & EXMEM_MemRead_i & memMatch;
  assign hazard    = IFID_valid_i & (hLu | hBex | hBmem);
  assign twoBubble = hLu & IFID_branch_i;

  // Leaving MEMWAIT happens on the same edge the miss clears, so act as the saved state now.
  assign curState = (state == MEMWAIT) ? retState : state;

  always_comb begin
    PCWrite_o     = 1'b1;
    IFID_Write_o  = 1'b1;
    IDEX_NoOp_o   = 1'b0;
    IFID_Flush_o  = 1'b0;
    pipe_freeze_o = 1'b0;
    stateNext     = state;
    retStateNext  = retState;
    remNext       = rem;
    hazInc        = 1'b0;
    frzInc        = 1'b0;
    if (!rst_i) begin
      PCWrite_o    = 1'b0;
      IFID_Write_o = 1'b0;
      IDEX_NoOp_o  = 1'b1;
      IFID_Flush_o = 1'b1;
    end else if (mem_stall_i) begin
      pipe_freeze_o = 1'b1;
      PCWrite_o     = 1'b0;
      IFID_Write_o  = 1'b0;
      frzInc        = 1'b1;
      stateNext     = MEMWAIT;
      retStateNext  = curState;
    end else if (curState == STALL) begin
      PCWrite_o    = 1'b0;
      IFID_Write_o = 1'b0;
      IDEX_NoOp_o  = 1'b1;
      hazInc       = 1'b1;
      remNext      = rem - 1'b1;
      stateNext    = (remNext == 1'b0) ? RUN : STALL;
    end else begin
      stateNext = RUN;
      if (hazard) begin
        PCWrite_o    = 1'b0;
        IFID_Write_o = 1'b0;
        IDEX_NoOp_o  = 1'b1;
        hazInc       = 1'b1;
        if (twoBubble) begin
          stateNext = STALL;
          remNext   = 1'b1;
        end
      end else begin
        IFID_Flush_o = branch_taken_i & IFID_branch_i & IFID_valid_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= RUN;
      retState  <= RUN;
      rem       <= 1'b0;
      hazardCnt <= '0;
      freezeCnt <= '0;
    end else begin
      state     <= stateNext;
      retState  <= retStateNext;
      rem       <= remNext;
      hazardCnt <= satInc(hazardCnt, hazInc);
      freezeCnt <= satInc(freezeCnt, frzInc);
    end
  end

  assign hazard_cnt_o = hazardCnt;
  assign freeze_cnt_o = freezeCnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: vector table, multi-cycle sequences, and random run against
// a pending-bubble reference model. A second instance with 4-bit counters covers saturation.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN, valid, used, br, tk, exRw, exMr, memMr, mst;
  logic [4:0] rs1, rs2, exRd, memRd;

  logic        pcw, ifw, noop, flush, frz;
  logic [31:0] hcnt, fcnt;
  logic        pcwS, ifwS, noopS, flushS, frzS;
  logic [3:0]  hcntS, fcntS;

  hazard_stall_ctrl #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rstN), .IFID_valid_i(valid), .IFID_rs1_addr_i(rs1),
    .IFID_rs2_addr_i(rs2), .IFID_rs2_used_i(used), .IFID_branch_i(br), .branch_taken_i(tk),
    .IDEX_rd_addr_i(exRd), .IDEX_RegWrite_i(exRw), .IDEX_MemRead_i(exMr),
    .EXMEM_rd_addr_i(memRd), .EXMEM_MemRead_i(memMr), .mem_stall_i(mst),
    .PCWrite_o(pcw), .IFID_Write_o(ifw), .IDEX_NoOp_o(noop), .IFID_Flush_o(flush),
    .pipe_freeze_o(frz), .hazard_cnt_o(hcnt), .freeze_cnt_o(fcnt));

  hazard_stall_ctrl #(.CNT_W(4)) dutS (
    .clk_i(clk), .rst_i(rstN), .IFID_valid_i(valid), .IFID_rs1_addr_i(rs1),
    .IFID_rs2_addr_i(rs2), .IFID_rs2_used_i(used), .IFID_branch_i(br), .branch_taken_i(tk),
    .IDEX_rd_addr_i(exRd), .IDEX_RegWrite_i(exRw), .IDEX_MemRead_i(exMr),
    .EXMEM_rd_addr_i(memRd), .EXMEM_MemRead_i(memMr), .mem_stall_i(mst),
    .PCWrite_o(pcwS), .IFID_Write_o(ifwS), .IDEX_NoOp_o(noopS), .IFID_Flush_o(flushS),
    .pipe_freeze_o(frzS), .hazard_cnt_o(hcntS), .freeze_cnt_o(fcntS));

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkOut(input string tag, input logic ePcw, input logic eNoop,
                        input logic eFlush, input logic eFrz);
    chk({tag, "_pcw"}, pcw, ePcw);
    chk({tag, "_ifw"}, ifw, ePcw);
    chk({tag, "_noop"}, noop, eNoop);
    chk({tag, "_flush"}, flush, eFlush);
    chk({tag, "_frz"}, frz, eFrz);
  endtask

  task automatic settle(); #5; endtask
  task automatic adv(); @(posedge clk); #1; endtask

  task automatic setIdle();
    rstN = 1'b1; valid = 1'b0; rs1 = '0; rs2 = '0; used = 1'b0; br = 1'b0; tk = 1'b0;
    exRd = '0; exRw = 1'b0; exMr = 1'b0; memRd = '0; memMr = 1'b0; mst = 1'b0;
  endtask

  task automatic doReset();
    setIdle();
    rstN = 1'b0;
    adv();
    rstN = 1'b1;
  endtask

  typedef struct {
    logic valid; logic [4:0] rs1; logic [4:0] rs2; logic used; logic br; logic tk;
    logic [4:0] exRd; logic exRw; logic exMr; logic [4:0] memRd; logic memMr; logic mst;
    logic ePcw; logic eNoop; logic eFlush; logic eFrz;
  } vec_t;

  vec_t vt[12];

  // Reference model: bubbles still owed plus unbounded event counts.
  int     pend;
  longint hcM, fcM;

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int bubblesNeeded();
    int  n;
    bit  mEx, mMem;
    n    = 0;
    mEx  = (exRd != 0) && (exRd == rs1 || (used && exRd == rs2));
    mMem = (memRd != 0) && (memRd == rs1 || (used && memRd == rs2));
    if (exMr && mEx) n = br ? 2 : 1;
    if (br && exRw && !exMr && mEx && n < 1) n = 1;
    if (br && memMr && mMem && n < 1) n = 1;
    return valid ? n : 0;
  endfunction

  initial begin
    vt[0]  = '{1, 5, 7, 1, 0, 0, 5, 1, 1, 0, 0, 0,  0, 1, 0, 0};
    vt[1]  = '{1, 0, 2, 1, 0, 0, 0, 1, 1, 0, 0, 0,  1, 0, 0, 0};
    vt[2]  = '{1, 1, 3, 0, 0, 0, 3, 1, 1, 0, 0, 0,  1, 0, 0, 0};
    vt[3]  = '{1, 1, 4, 1, 0, 0, 4, 1, 1, 0, 0, 0,  0, 1, 0, 0};
    vt[4]  = '{1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0};
    vt[5]  = '{1, 8, 0, 1, 1, 1, 8, 1, 0, 0, 0, 0,  0, 1, 0, 0};
    vt[6]  = '{1, 1, 9, 1, 1, 0, 0, 0, 0, 9, 1, 0,  0, 1, 0, 0};
    vt[7]  = '{1, 1, 9, 1, 1, 1, 0, 0, 0, 9, 0, 0,  1, 0, 1, 0};
    vt[8]  = '{0, 5, 7, 1, 1, 1, 5, 1, 1, 0, 0, 0,  1, 0, 0, 0};
    vt[9]  = '{1, 5, 7, 1, 0, 0, 5, 1, 1, 0, 0, 1,  0, 0, 0, 1};
    vt[10] = '{1, 5, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0,  1, 0, 0, 0};
    vt[11] = '{1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0,  1, 0, 1, 0};

    setIdle();
    adv();

    // Reset state
    rstN = 1'b0; mst = 1'b1; settle();
    chkOut("rst", 1'b0, 1'b1, 1'b1, 1'b0);
    adv();
    setIdle(); settle();
    chk("rst_hcnt", hcnt, 0);
    chk("rst_fcnt", fcnt, 0);
    chkOut("post_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    adv();

    // Single-cycle vector table, each from a fresh RUN state
    for (int i = 0; i < 12; i++) begin
      doReset();
      valid = vt[i].valid; rs1 = vt[i].rs1; rs2 = vt[i].rs2; used = vt[i].used;
      br = vt[i].br; tk = vt[i].tk; exRd = vt[i].exRd; exRw = vt[i].exRw; exMr = vt[i].exMr;
      memRd = vt[i].memRd; memMr = vt[i].memMr; mst = vt[i].mst;
      settle();
      chkOut($sformatf("vec%0d", i), vt[i].ePcw, vt[i].eNoop, vt[i].eFlush, vt[i].eFrz);
      adv();
    end

    // lw x5 then add x6,x5,x7: one bubble, counter 0 -> 1
    doReset();
    valid = 1; rs1 = 5; rs2 = 7; used = 1; exRd = 5; exRw = 1; exMr = 1;
    settle();
    chkOut("lu_c1", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lu_hcnt0", hcnt, 0);
    adv();
    setIdle(); valid = 1; rs1 = 5; rs2 = 7; used = 1; memRd = 5; memMr = 1;
    settle();
    chkOut("lu_c2", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_hcnt1", hcnt, 1);
    adv();

    // lw x5 then beq x5,x0 taken: two bubbles, flush on the third cycle
    doReset();
    valid = 1; rs1 = 5; rs2 = 0; used = 1; br = 1; tk = 1; exRd = 5; exRw = 1; exMr = 1;
    settle();
    chkOut("lub_c1", 1'b0, 1'b1, 1'b0, 1'b0);
    adv();
    exRd = 0; exRw = 0; exMr = 0; memRd = 5; memMr = 1;
    settle();
    chkOut("lub_c2", 1'b0, 1'b1, 1'b0, 1'b0);
    adv();
    memRd = 0; memMr = 0;
    settle();
    chkOut("lub_c3", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("lub_hcnt", hcnt, 2);
    adv();

    // Miss of 4 cycles landing on the STALL cycle: freeze, then the owed bubble
    doReset();
    valid = 1; rs1 = 5; used = 1; br = 1; tk = 1; exRd = 5; exRw = 1; exMr = 1;
    settle(); adv();
    exRd = 0; exRw = 0; exMr = 0; memRd = 5; memMr = 1; mst = 1;
    for (int c = 0; c < 4; c++) begin
      settle();
      chkOut($sformatf("mw_frz%0d", c), 1'b0, 1'b0, 1'b0, 1'b1);
      adv();
    end
    mst = 0;
    settle();
    chkOut("mw_bubble", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mw_fcnt", fcnt, 4);
    adv();
    memRd = 0; memMr = 0;
    settle();
    chkOut("mw_resume", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("mw_hcnt", hcnt, 2);
    adv();

    // Reset asserted while frozen abandons the wait
    doReset();
    mst = 1;
    settle(); adv();
    settle(); adv();
    rstN = 0;
    settle();
    chkOut("rmw_held", 1'b0, 1'b1, 1'b1, 1'b0);
    adv();
    setIdle(); valid = 1; rs1 = 3;
    settle();
    chkOut("rmw_after", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rmw_fcnt", fcnt, 0);
    chk("rmw_hcnt", hcnt, 0);
    adv();

    // 20 load-use bubbles: 4-bit counter pins at 15, 32-bit one reaches 20
    doReset();
    valid = 1; rs1 = 6; exRd = 6; exRw = 1; exMr = 1;
    for (int c = 0; c < 20; c++) adv();
    setIdle(); settle();
    chk("sat_hcnt4", hcntS, 4'hF);
    chk("sat_hcnt32", hcnt, 20);
    adv();

    // Randomized run against the reference model
    doReset();
    pend = 0; hcM = 0; fcM = 0;
    for (int c = 0; c < 3000; c++) begin
      bit     ePcw, eNoop, eFlush, eFrz;
      int     n;
      rstN  = ($urandom_range(0, 63) != 0);
      valid = ($urandom_range(0, 7) != 0);
      rs1   = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      used  = 1'($urandom); br = ($urandom_range(0, 2) == 0); tk = 1'($urandom);
      exRd  = 5'($urandom_range(0, 3)); exRw = 1'($urandom); exMr = ($urandom_range(0, 2) == 0);
      memRd = 5'($urandom_range(0, 3)); memMr = ($urandom_range(0, 2) == 0);
      mst   = ($urandom_range(0, 5) == 0);
      settle();
      ePcw = 1; eNoop = 0; eFlush = 0; eFrz = 0;
      if (!rstN) begin
        ePcw = 0; eNoop = 1; eFlush = 1;
      end else if (mst) begin
        ePcw = 0; eFrz = 1;
      end else if (pend > 0) begin
        ePcw = 0; eNoop = 1;
      end else begin
        n = bubblesNeeded();
        if (n > 0) begin
          ePcw = 0; eNoop = 1;
        end else begin
          eFlush = valid & br & tk;
        end
      end
      chkOut("rnd", ePcw, eNoop, eFlush, eFrz);
      chk("rnd_hcnt", hcnt, 64'(sat(hcM, 32)));
      chk("rnd_fcnt", fcnt, 64'(sat(fcM, 32)));
      chk("rnd_hcnt4", hcntS, 64'(sat(hcM, 4)));
      chk("rnd_fcnt4", fcntS, 64'(sat(fcM, 4)));
      if (!rstN) begin
        pend = 0; hcM = 0; fcM = 0;
      end else if (mst) begin
        fcM++;
      end else if (pend > 0) begin
        pend--; hcM++;
      end else begin
        n = bubblesNeeded();
        if (n > 0) begin
          pend = n - 1; hcM++;
        end
      end
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
